column_slot_allocator: RTL
==========================

Name: column_slot_allocator

Overview:
- Parametrised, clocked successor to the Connect4 drop-position calculator.
- Tracks fill height per column for a COLS x ROWS board.
- Converts an active-low one-hot column selection into a linear cell index (row*COLS + col).
- Reports rejects, per-column full flags and board-full; requests use a one-shot handshake (one allocation per request).
- Sits between the debounced column buttons and the board-state/display logic.

Parameters:
- COLS, 4: number of columns; width of sel_col_n.
- ROWS, 4: number of rows; maximum height per column.
- POS_W, $clog2(COLS*ROWS+1): width of position; all-ones is the "no position" code.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- new_game  in  1  synchronous clear of all column heights
- req_valid  in  1  request strobe/level from input logic
- sel_col_n  in  COLS  active-low one-hot column select (bit k low = column k)
- pos_valid  out  1  one-cycle pulse: position holds a fresh allocation
- position  out  POS_W  linear cell index; all-ones when no valid allocation
- reject  out  1  one-cycle pulse: request refused (column full or invalid select)
- col_full  out  COLS  bit k high when column k height == ROWS
- board_full  out  1  high when all col_full bits are high
- height_of_sel  out  $clog2(ROWS+1)  current height of the selected column, combinational from sel_col_n; 0 if the select is invalid

Behaviour:
- Reset (reset_n low, asynchronous):
  - all heights 0; state IDLE; position all-ones.
  - pos_valid, reject, col_full, board_full all 0.
- Heights: one counter per column, width $clog2(ROWS+1). Saturates at ROWS; never wraps.
- FSM states: IDLE, RESP, HOLD.
- IDLE, req_valid=1, sampled on a clk edge:
  - Valid select (exactly one bit of sel_col_n low, column k not full): next cycle is RESP; position = height[k]*COLS + k; pos_valid=1; height[k] increments in the same edge.
  - Invalid select (zero or multiple bits low) or column k full: next cycle is RESP; reject=1; position all-ones; no height change.
- RESP: lasts exactly one cycle, then HOLD. pos_valid and reject return to 0.
- position hold rule: after a valid allocation, position holds its value until the next accepted request or new_game. After a reject it stays all-ones.
- HOLD: waits for req_valid=0, then goes to IDLE. A held request never allocates twice.
- Latency: request sampled at edge N produces the pos_valid/reject pulse during cycle N+1. The earliest next acceptance is the edge after req_valid falls.
- new_game: highest priority after reset. Clears all heights, sets position to all-ones, forces state to HOLD (a request still held must be released first), and suppresses any pulse that cycle.
- col_full and board_full are registered from the heights and update in the same edge as the height change.
- Arithmetic: height*COLS + k is computed at POS_W bits. The maximum valid index COLS*ROWS-1 is always below all-ones.

Optional Feature:
- Macro: SLOT_UNDO_EN.
- When defined:
  - Adds input undo (1 bit).
  - Adds a one-entry last-column register, valid after an allocation, cleared by undo, new_game and reset.
  - undo pulse in IDLE with the register valid: decrements that column's height, sets position to the freed cell index, pulses pos_valid for one cycle, clears the register.
  - undo with the register invalid: pulses reject.
  - undo and req_valid together in IDLE: undo wins and the request waits.
- When not defined: no undo port or logic; behaviour is exactly as above.

Test Plan:
- Reset, then request sel_col_n=4'b1110 four times with a release between each -> positions 0,4,8,12, each with a pos_valid pulse; col_full=4'b0001 after the fourth.
- Fifth request on column 0 -> reject pulse, position 5'b11111, heights unchanged.
- Hold req_valid high 10 cycles with sel_col_n=4'b1011 -> exactly one pos_valid, position 2; height of column 2 is 1.
- sel_col_n=4'b1100 or 4'b1111 with req_valid -> reject, no height change.
- Fill all 16 cells in mixed order -> board_full=1 on the edge of the last allocation; new_game -> heights 0, col_full=0, next column-3 request gives position 3.
- Assert reset_n low mid-RESP with COLS=7, ROWS=6 -> all outputs return to reset values immediately; next column-6 request gives position 6. With SLOT_UNDO_EN defined: allocate col 1 (position 1), undo -> pos_valid with position 1, height back to 0; second undo -> reject.

Source files
------------

// File: rtl/column_slot_allocator.sv
// Column fill tracker: turns an active-low one-hot column select into a linear cell index, one allocation per request.
// Optional SLOT_UNDO_EN macro adds an undo input that frees the most recently allocated cell.
module column_slot_allocator #(
  parameter int COLS  = 4,
  parameter int ROWS  = 4,
  parameter int POS_W = $clog2(COLS*ROWS+1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       new_game,
  input  logic                       req_valid,
  input  logic [COLS-1:0]            sel_col_n,
`ifdef SLOT_UNDO_EN
  input  logic                       undo,
`endif
  output logic                       pos_valid,
  output logic [POS_W-1:0]           position,
  output logic                       reject,
  output logic [COLS-1:0]            col_full,
  output logic                       board_full,
  output logic [$clog2(ROWS+1)-1:0]  height_of_sel
);

  localparam int HW = $clog2(ROWS+1);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [POS_W-1:0] NO_POS = '1;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     height [COLS];
  logic [HW-1:0]     height_nxt [COLS];
  logic [POS_W-1:0]  position_nxt;
  logic              pos_valid_nxt, reject_nxt;
  logic [COLS-1:0]   col_full_nxt;
  logic              sel_ok;
  logic [CW-1:0]     sel_idx;
  logic [HW-1:0]     sel_height;

`ifdef SLOT_UNDO_EN
  logic              last_vld, last_vld_nxt;
  logic [CW-1:0]     last_col, last_col_nxt;
  logic [HW-1:0]     undo_height;
`endif

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < COLS; k++) begin
      if (!sel_col_n[k]) sel_idx = CW'(k);
    end
    sel_ok        = ($countones(~sel_col_n) == 1);
    sel_height    = sel_ok ? height[sel_idx] : '0;
    height_of_sel = sel_height;
  end

  always_comb begin
    state_nxt     = state;
    height_nxt    = height;
    position_nxt  = position;
    pos_valid_nxt = 1'b0;
    reject_nxt    = 1'b0;
`ifdef SLOT_UNDO_EN
    last_vld_nxt  = last_vld;
    last_col_nxt  = last_col;
    undo_height   = height[last_col] - HW'(1);
`endif
    if (new_game) begin
      for (int k = 0; k < COLS; k++) height_nxt[k] = '0;
      position_nxt = NO_POS;
      state_nxt    = HOLD;
`ifdef SLOT_UNDO_EN
      last_vld_nxt = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SLOT_UNDO_EN
          // Undo completes in place so a request raised alongside it is served next.
          if (undo) begin
            if (last_vld) begin
              height_nxt[last_col] = undo_height;
              position_nxt  = POS_W'(undo_height) * POS_W'(COLS) + POS_W'(last_col);
              pos_valid_nxt = 1'b1;
              last_vld_nxt  = 1'b0;
            end else begin
              reject_nxt    = 1'b1;
              position_nxt  = NO_POS;
            end
          end else
`endif
          if (req_valid) begin
            state_nxt = RESP;
            if (sel_ok && (sel_height != HW'(ROWS))) begin
              height_nxt[sel_idx] = sel_height + HW'(1);
              position_nxt  = POS_W'(sel_height) * POS_W'(COLS) + POS_W'(sel_idx);
              pos_valid_nxt = 1'b1;
`ifdef SLOT_UNDO_EN
              last_vld_nxt  = 1'b1;
              last_col_nxt  = sel_idx;
`endif
            end else begin
              reject_nxt   = 1'b1;
              position_nxt = NO_POS;
            end
          end
        end
        RESP:    state_nxt = HOLD;
        HOLD:    if (!req_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    for (int k = 0; k < COLS; k++) col_full_nxt[k] = (height_nxt[k] == HW'(ROWS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      for (int k = 0; k < COLS; k++) height[k] <= '0;
      position   <= NO_POS;
      pos_valid  <= 1'b0;
      reject     <= 1'b0;
      col_full   <= '0;
      board_full <= 1'b0;
`ifdef SLOT_UNDO_EN
      last_vld   <= 1'b0;
      last_col   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      height     <= height_nxt;
      position   <= position_nxt;
      pos_valid  <= pos_valid_nxt;
      reject     <= reject_nxt;
      col_full   <= col_full_nxt;
      board_full <= &col_full_nxt;
`ifdef SLOT_UNDO_EN
      last_vld   <= last_vld_nxt;
      last_col   <= last_col_nxt;
`endif
    end
  end

endmodule
